rx_protocol: RTL

//  Serial receive stage; the downstream partner of the token-ring serial transmitter.

---
 rtl/txrx_pkg.sv | 15 +
 rtl/rx_protocol_if.sv | 22 ++
 rtl/rx_deser.sv | 32 +++
 rtl/rx_protocol.sv | 125 ++++++++++++
 4 files changed

// File: rtl/txrx_pkg.sv
// Shared definitions for the token-ring serial link (transmitter and receiver):
// payload/header geometry, header pattern and the receiver state encoding.
package txrx_pkg;

  localparam int DATA_W = 55;
  localparam int HDR_W  = 6;
  localparam logic [HDR_W-1:0] HDR = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_protocol_if.sv
// Serial line plus payload handoff between the receive stage and the router core.
// master: line driver / consuming core; slave: the receive stage.
interface rx_protocol_if import txrx_pkg::*; ();

  logic              S_Data;
  logic              RX_ack;
  logic [DATA_W-1:0] RX_Data;
  logic              RX_valid;
  logic              hdr_err;
  logic              overrun;

  modport master (
    output S_Data, RX_ack,
    input  RX_Data, RX_valid, hdr_err, overrun
  );

  modport slave (
    input  S_Data, RX_ack,
    output RX_Data, RX_valid, hdr_err, overrun
  );

endinterface

// File: rtl/rx_deser.sv
// Payload deserializer. Holds the first W-1 payload bits; the word output
// appends the bit currently on the line so the complete word is available on
// the very edge that samples the final payload bit.
module rx_deser import txrx_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_shift_en,
  input  logic         i_clear,
  input  logic         i_bit,
  output logic [W-1:0] o_word
);

  logic [W-2:0] r_sh;

  // MSB-first shift register; clear wins over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_clear) begin
      r_sh <= '0;
    end else if (i_shift_en) begin
      r_sh <= {r_sh[W-3:0], i_bit};
    end else begin
      r_sh <= r_sh;
    end
  end

  assign o_word = {r_sh, i_bit};

endmodule

// File: rtl/rx_protocol.sv
// Serial receive stage: hunts for the 6-bit header 011111 on S_Data, shifts in
// the 55-bit payload MSB first and hands it to the core with valid/ack.
// Optional build macro RX_SYNC_EN: passes S_Data through a 2-flop synchronizer
// (resetting to the idle level 1) before the FSM, adding two cycles of latency.
module rx_protocol import txrx_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  rx_protocol_if.slave bus
);

  rx_state_t         r_state;
  logic [2:0]        r_hcnt;
  logic [5:0]        r_dcnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_hdr_err;
  logic              r_overrun;

  logic              w_bit;
  logic [DATA_W-1:0] w_word;
  logic              w_shift_en;
  logic              w_clear;

`ifdef RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer for the line; resets to idle-high so no false header
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.S_Data};
    end
  end

  assign w_bit = r_sync[1];
`else
  assign w_bit = bus.S_Data;
`endif

  assign w_shift_en = (r_state == ST_DATA);
  assign w_clear    = (r_state == ST_IDLE);

  rx_deser #(.W(DATA_W)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_shift_en),
    .i_clear    (w_clear),
    .i_bit      (w_bit),
    .o_word     (w_word)
  );

  // Frame FSM with registered handoff, valid/ack handshake and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hcnt    <= 3'd0;
      r_dcnt    <= 6'd0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_hdr_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // pulses are one cycle wide; ack drops valid unless a frame lands now
      r_hdr_err <= 1'b0;
      r_overrun <= 1'b0;
      if (bus.RX_ack) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_bit == HDR[HDR_W-1]) begin
            r_state <= ST_HDR;
            r_hcnt  <= 3'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_HDR: begin
          if (w_bit != HDR[HDR_W-1]) begin
            if (r_hcnt == 3'(HDR_W - 1)) begin
              r_state <= ST_DATA;
              r_hcnt  <= 3'd0;
              r_dcnt  <= 6'd0;
            end else begin
              r_hcnt <= r_hcnt + 3'd1;
            end
          end else begin
            // broken header: this 0 is the start of a fresh header attempt
            r_hdr_err <= 1'b1;
            r_hcnt    <= 3'd1;
          end
        end

        ST_DATA: begin
          if (r_dcnt == 6'(DATA_W - 1)) begin
            r_data    <= w_word;
            r_valid   <= 1'b1;
            r_overrun <= r_valid & ~bus.RX_ack;
            r_dcnt    <= 6'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_dcnt <= r_dcnt + 6'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_hcnt  <= 3'd0;
          r_dcnt  <= 6'd0;
        end
      endcase
    end
  end

  assign bus.RX_Data  = r_data;
  assign bus.RX_valid = r_valid;
  assign bus.hdr_err  = r_hdr_err;
  assign bus.overrun  = r_overrun;

endmodule
